fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the combinational-read instruction memory.
- Captures the returned instruction word with its PC into a 2-entry buffer.
- Hands {pc, instr} to decode over a valid/ready handshake, and handles control-flow redirects and misaligned-target faults.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buf.sv | 52 +++++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Entry layout, FSM states and default reset PC.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

  typedef enum logic {
    RUN,
    FAULT
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry shift FIFO between fetch and decode.
// Head stays at slot 0; it keeps its last value once drained.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t slot0;
  entry_t slot1;

  assign head = slot0;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= din;
          end else begin
            slot0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem addressing, redirect
// handling and a small buffer toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = fetch_pkg::XLEN,
  parameter int              ADDR_WIDTH = 16,
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [XLEN-1:0]       imem_instr,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_instr,
  output logic                  fault,
  output logic [XLEN-1:0]       fault_pc
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  state_t          state;
  state_t          state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_d;
  logic            fault_d;
  logic [XLEN-1:0] fault_pc_d;
  logic            push;
  logic            pop;
  logic [1:0]      count;
  entry_t          head;
  entry_t          din;

  assign imem_addr = fetch_pc[ADDR_WIDTH+1:2];
  assign din       = '{pc: fetch_pc, instr: imem_instr};
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  // Redirect kills the head in its own cycle.
  assign out_valid = (count != 2'd0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d    = state;
    pc_d       = fetch_pc;
    fault_d    = fault;
    fault_pc_d = fault_pc;
    push       = 1'b0;
    if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        state_d = RUN;
        fault_d = 1'b0;
      end else begin
        state_d    = FAULT;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end
    end else begin
      unique case (state)
        RUN: begin
          push = (count < FULL) | pop;
          if (push) pc_d = fetch_pc + XLEN'(4);
        end
        FAULT: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state    <= state_d;
      fetch_pc <= pc_d;
      fault    <= fault_d;
      fault_pc <= fault_pc_d;
    end
  end

  fetch_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases queue the
// expected {pc, instr} stream; a monitor checks each handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [65536];
  logic [63:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // Monitor: every completed handshake must match the queue head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got pc=%h instr=%h, want none",
                 out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          errors++;
          $display("FAIL stream: got pc=%h instr=%h, want pc=%h instr=%h",
                   out_pc, out_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic expect_out(input logic [31:0] pc,
                            input logic [31:0] ins);
    exp_q.push_back({pc, ins});
  endtask

  task automatic check_empty(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_pc"}, out_pc, 32'h0);
    chk({tag, "_instr"}, out_instr, 32'h0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_fault_pc"}, fault_pc, 32'h0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = ready;
    step(2);
    rst = 1'b0;
  endtask

  // Redirect lasts one cycle; head must be hidden while it is up
  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    #1;
    chk("redir_valid_low", 32'(out_valid), 32'd0);
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int bad;
    for (int k = 0; k < 65536; k++) mem[k] = 32'(k) + 32'h13;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;

    // Streaming from reset
    rst = 1'b1;
    step(2);
    check_reset("rst0");
    expect_out(32'h0, 32'h13);
    expect_out(32'h4, 32'h14);
    expect_out(32'h8, 32'h15);
    rst = 1'b0;
    chk("cyc0_valid", 32'(out_valid), 32'd0);
    step(1);
    chk("cyc1_valid", 32'(out_valid), 32'd1);
    chk("cyc1_pc", out_pc, 32'h0);
    step(3);
    out_ready = 1'b0;
    check_empty("stream_done");

    // Backpressure from reset
    do_reset(1'b0);
    step(5);
    chk("bp_addr", 32'(imem_addr), 32'h2);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head", out_pc, 32'h0);
    expect_out(32'h0, 32'h13);
    expect_out(32'h4, 32'h14);
    expect_out(32'h8, 32'h15);
    expect_out(32'hC, 32'h16);
    out_ready = 1'b1;
    step(4);
    out_ready = 1'b0;
    check_empty("bp_done");

    // Redirect with full buffer {0x0, 0x4}
    do_reset(1'b0);
    step(3);
    out_ready = 1'b1;
    expect_out(32'h100, 32'h53);
    expect_out(32'h104, 32'h54);
    redirect(32'h100);
    step(3);
    out_ready = 1'b0;
    check_empty("redir_done");

    // Misaligned target faults, then aligned recovery
    out_ready = 1'b1;
    redirect(32'h102);
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_pc", fault_pc, 32'h102);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b0 || fault !== 1'b1) bad++;
      step(1);
    end
    chk("fault_hold_bad_cycles", 32'(bad), 32'd0);
    redirect(32'h105);
    chk("fault_again", 32'(fault), 32'd1);
    chk("fault_pc_upd", fault_pc, 32'h105);
    expect_out(32'h200, 32'h93);
    redirect(32'h200);
    chk("fault_clear", 32'(fault), 32'd0);
    step(2);
    out_ready = 1'b0;
    check_empty("fault_done");

    // Word address wraps inside the memory
    out_ready = 1'b1;
    expect_out(32'h3FFFC, 32'h10012);
    expect_out(32'h40000, 32'h13);
    redirect(32'h3FFFC);
    chk("wrap_addr_hi", 32'(imem_addr), 32'hFFFF);
    step(1);
    chk("wrap_addr_lo", 32'(imem_addr), 32'h0);
    step(2);
    out_ready = 1'b0;
    check_empty("wrap_done");

    // Reset beats a simultaneous redirect on a full buffer
    step(3);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h301;
    out_ready = 1'b1;
    step(1);
    check_reset("rst1");
    rst = 1'b0;
    redirect_valid = 1'b0;
    expect_out(32'h0, 32'h13);
    step(2);
    out_ready = 1'b0;
    step(3);
    check_empty("final");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
